alsu_result_display: RTL and testbench

Downstream stage of the ALSU that consumes its registered 6-bit result and its LED error indication and drives a 4-digit multiplexed 7-segment display. It converts the binary result to decimal with a sequential double-dabble engine and scans the digits using a refresh counter. While the ALSU reports an invalid operation, the display shows "Err". The block sits between the ALSU outputs and the board display pins.

---
 rtl/alsu_result_display_if.sv | 23 ++
 rtl/alsu_result_display.sv | 204 ++++++++++++++++++++
 tb/tb_alsu_result_display.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_result_display_if.sv
// Display-side bundle between the ALSU result path and the 7-segment driver.
// Carries the ALSU result/error inputs and the board-facing display outputs.
// Ports: result[5:0], err_flag (to display); seg[6:0], dp, an[3:0], busy (from display).
interface alsu_result_display_if;
   logic [5:0] result;
   logic       err_flag;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       busy;

   // master: the ALSU side that supplies the value and watches the pins
   modport master (
      output result, err_flag,
      input  seg, dp, an, busy
   );

   // slave: the display driver itself
   modport slave (
      input  result, err_flag,
      output seg, dp, an, busy
   );
endinterface

// File: rtl/alsu_result_display.sv
// Purpose: binary-to-BCD (double dabble) plus 4-digit multiplexed 7-seg driver for the ALSU result, "Err" on invalid op.
// Latency: result change -> display regs 8 cycles; seg/an/dp registered, one cycle behind the digit index.
// Backpressure: none; result changes during a conversion are ignored and picked up by the IDLE compare afterwards.
// Ports: clk, rst (async active-low), bus (slave modport: result, err_flag in; seg, dp, an, busy out).
// Optional: define ALSU_DISP_HEX_EN to show hex of the committed value on digits 3 and 2.
module alsu_result_display #(
   parameter logic [15:0] REFRESH_DIV    = 16'd50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   alsu_result_display_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // symbol codes: 0..15 hex digits, then 'r' and blank
   localparam logic [4:0] SYM_E     = 5'd14;
   localparam logic [4:0] SYM_R     = 5'd16;
   localparam logic [4:0] SYM_BLANK = 5'd17;

   state_t      state, state_nxt;
   logic        cap_vld;
   logic [5:0]  captured;
   logic [5:0]  shreg;
   logic [7:0]  bcd;
   logic [7:0]  bcd_adj;
   logic [2:0]  iter;
   logic [3:0]  ones, tens;
   logic        start;
   logic        busy_c;
`ifdef ALSU_DISP_HEX_EN
   logic [5:0]  disp_val;
`endif

   logic [15:0] refresh_cnt;
   logic [1:0]  digit_idx;
   logic [4:0]  sym;
   logic [6:0]  pat;
   logic [3:0]  an_onehot;
   logic [6:0]  seg_q;
   logic [3:0]  an_q;
   logic        dp_q;

   // active-high gfedcba patterns
   function automatic logic [6:0] sym_to_pat(input logic [4:0] s);
      case (s)
         5'd0:    sym_to_pat = 7'h3F;
         5'd1:    sym_to_pat = 7'h06;
         5'd2:    sym_to_pat = 7'h5B;
         5'd3:    sym_to_pat = 7'h4F;
         5'd4:    sym_to_pat = 7'h66;
         5'd5:    sym_to_pat = 7'h6D;
         5'd6:    sym_to_pat = 7'h7D;
         5'd7:    sym_to_pat = 7'h07;
         5'd8:    sym_to_pat = 7'h7F;
         5'd9:    sym_to_pat = 7'h6F;
         5'd10:   sym_to_pat = 7'h77;
         5'd11:   sym_to_pat = 7'h7C;
         5'd12:   sym_to_pat = 7'h39;
         5'd13:   sym_to_pat = 7'h5E;
         5'd14:   sym_to_pat = 7'h79;
         5'd15:   sym_to_pat = 7'h71;
         5'd16:   sym_to_pat = 7'h50;
         default: sym_to_pat = 7'h00;
      endcase
   endfunction

   // A conversion is needed on the first result after reset or whenever the
   // input no longer matches what was last converted.
   assign start = !cap_vld || (bus.result != captured);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         S_SHIFT: if (iter == 3'd5) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_c = (state != S_IDLE);
   end

   // double-dabble correction: bump any nibble >= 5 before it is doubled
   always_comb begin
      bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
      bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
   end

   // conversion datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_vld  <= 1'b0;
         captured <= 6'd0;
         shreg    <= 6'd0;
         bcd      <= 8'd0;
         iter     <= 3'd0;
         ones     <= 4'd0;
         tens     <= 4'd0;
`ifdef ALSU_DISP_HEX_EN
         disp_val <= 6'd0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cap_vld  <= 1'b1;
                  captured <= bus.result;
                  shreg    <= bus.result;
                  bcd      <= 8'd0;
                  iter     <= 3'd0;
               end
            end
            S_SHIFT: begin
               {bcd, shreg} <= {bcd_adj, shreg} << 1;
               iter         <= iter + 3'd1;
            end
            S_DONE: begin
               ones <= bcd[3:0];
               tens <= bcd[7:4];
`ifdef ALSU_DISP_HEX_EN
               disp_val <= captured;
`endif
            end
            default: ;
         endcase
      end
   end

   // digit scan: each digit stays lit for REFRESH_DIV cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_cnt <= 16'd0;
         digit_idx   <= 2'd0;
      end else if (refresh_cnt == REFRESH_DIV - 16'd1) begin
         refresh_cnt <= 16'd0;
         digit_idx   <= digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 16'd1;
      end
   end

   // digit content; error mode is taken live from err_flag so it overrides
   // the numeric value without waiting for any conversion
   always_comb begin
      sym = SYM_BLANK;
      if (bus.err_flag) begin
         case (digit_idx)
            2'd3:       sym = SYM_E;
            2'd2, 2'd1: sym = SYM_R;
            default:    sym = SYM_BLANK;
         endcase
      end else begin
         case (digit_idx)
            2'd0:    sym = {1'b0, ones};
            2'd1:    sym = (tens == 4'd0) ? SYM_BLANK : {1'b0, tens};
`ifdef ALSU_DISP_HEX_EN
            2'd2:    sym = {1'b0, disp_val[3:0]};
            2'd3:    sym = {3'b000, disp_val[5:4]};
`endif
            default: sym = SYM_BLANK;
         endcase
      end
   end

   always_comb begin
      pat       = sym_to_pat(sym);
      an_onehot = 4'b0001 << digit_idx;
   end

   // registered pins, polarity applied here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
         an_q  <= SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
         dp_q  <= SEG_ACTIVE_LOW;
      end else begin
         seg_q <= SEG_ACTIVE_LOW ? ~pat : pat;
         an_q  <= SEG_ACTIVE_LOW ? ~an_onehot : an_onehot;
         dp_q  <= SEG_ACTIVE_LOW;
      end
   end

   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
   assign bus.dp   = dp_q;
   assign bus.busy = busy_c;

endmodule

// File: tb/tb_alsu_result_display.sv
// Bench for alsu_result_display with REFRESH_DIV=4 and active-low pins.
// Expected digits come from decimal/hex arithmetic on the applied value.
module tb_alsu_result_display;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

`ifdef ALSU_DISP_HEX_EN
   localparam bit HEX = 1'b1;
`else
   localparam bit HEX = 1'b0;
`endif

   alsu_result_display_if bus();

   alsu_result_display #(
      .REFRESH_DIV    (16'd4),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // symbol -> active-high pattern; 16 = 'r', 17 = blank
   function automatic logic [6:0] pat(input int s);
      logic [6:0] t [0:17];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
            7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h50, 7'h00};
      return t[s];
   endfunction

   // expected active-low seg for digit d showing value v
   function automatic logic [6:0] exp_seg(input int d, input int v, input bit err);
      int s;
      if (err) s = (d == 3) ? 14 : (d == 0) ? 17 : 16;
      else begin
         case (d)
            0:       s = v % 10;
            1:       s = (v / 10 == 0) ? 17 : v / 10;
            2:       s = HEX ? v % 16 : 17;
            default: s = HEX ? v / 16 : 17;
         endcase
      end
      return ~pat(s);
   endfunction

   // wait (bounded) until digit d is enabled, return its segments
   task automatic get_digit(input int d, output logic [6:0] s, output bit ok);
      logic [3:0] want;
      want = ~(4'b0001 << d);
      ok = 1'b0;
      s  = 7'hxx;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.an === want) begin
            ok = 1'b1;
            s  = bus.seg;
         end
      end
   endtask

   task automatic settle(input int v);
      @(negedge clk);
      bus.result = 6'(v);
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset;
      int busy_cnt;
      logic [3:0] exp_an;
      logic [6:0] s;
      bit ok;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.result   = 6'($urandom_range(63));
         bus.err_flag = 1'($urandom_range(1));
         @(negedge clk);
         total++;
         if ({bus.seg, bus.an, bus.dp, bus.busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold seg=%h an=%h dp=%b busy=%b want 7f f 1 0",
                     bus.seg, bus.an, bus.dp, bus.busy);
         end
      end
      bus.result   = 6'd0;
      bus.err_flag = 1'b0;
      rst          = 1'b1;
      busy_cnt     = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
         exp_an = ~(4'b0001 << ((k / 4) % 4));
         total++;
         if (bus.an !== exp_an) begin
            bad++;
            $display("FAIL an_scan k=%0d got=%h want=%h", k, bus.an, exp_an);
         end
         if (k == 0) begin
            total++;
            if (bus.seg !== 7'h40) begin
               bad++;
               $display("FAIL first_seg got=%h want=40", bus.seg);
            end
         end
      end
      total++;
      if (busy_cnt != 7) begin
         bad++;
         $display("FAIL busy_len got=%0d want=7", busy_cnt);
      end
      for (int d = 0; d < 4; d++) begin
         get_digit(d, s, ok);
         total++;
         if (!ok || s !== exp_seg(d, 0, 1'b0)) begin
            bad++;
            $display("FAIL zero_d%0d ok=%0b got=%h want=%h", d, ok, s, exp_seg(d, 0, 1'b0));
         end
      end
   endtask

   task automatic test_values;
      int vals [$];
      logic [6:0] s;
      bit ok;
      vals = '{45, 7, 63, 0, 9, 10};
      for (int i = 0; i < 10; i++) vals.push_back(int'($urandom_range(63)));
      foreach (vals[j]) begin
         settle(vals[j]);
         for (int d = 0; d < 4; d++) begin
            get_digit(d, s, ok);
            total++;
            if (!ok || s !== exp_seg(d, vals[j], 1'b0)) begin
               bad++;
               $display("FAIL value_%0d_d%0d ok=%0b got=%h want=%h",
                        vals[j], d, ok, s, exp_seg(d, vals[j], 1'b0));
            end
         end
      end
   endtask

   task automatic test_midchange;
      int idx;
      int v;
      settle(10);
      @(negedge clk);
      bus.result = 6'd45;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         if (k == 2) bus.result = 6'd63;
         if (k == 0 || k == 6 || k == 7 || k == 8 || k == 15) begin
            total++;
            if (bus.busy !== ((k == 7 || k == 15) ? 1'b0 : 1'b1)) begin
               bad++;
               $display("FAIL mid_busy k=%0d got=%b", k, bus.busy);
            end
         end
         if (k >= 8) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (bus.an[i] === 1'b0) idx = i;
            v = (k == 16) ? 63 : 45;
            total++;
            if (bus.seg !== exp_seg(idx, v, 1'b0)) begin
               bad++;
               $display("FAIL mid_seg k=%0d d%0d got=%h want=%h", k, idx, bus.seg,
                        exp_seg(idx, v, 1'b0));
            end
         end
      end
   endtask

   task automatic test_error;
      logic [6:0] s;
      bit ok;
      int idx;
      int v;
      settle(12);
      @(negedge clk);
      bus.err_flag = 1'b1;
      for (int d = 3; d >= 0; d--) begin
         get_digit(d, s, ok);
         total++;
         if (!ok || s !== exp_seg(d, 12, 1'b1)) begin
            bad++;
            $display("FAIL err_d%0d ok=%0b got=%h want=%h", d, ok, s, exp_seg(d, 12, 1'b1));
         end
      end
      bus.err_flag = 1'b0;
      @(negedge clk);
      idx = 0;
      for (int i = 0; i < 4; i++) if (bus.an[i] === 1'b0) idx = i;
      total++;
      if (bus.seg !== exp_seg(idx, 12, 1'b0)) begin
         bad++;
         $display("FAIL err_release d%0d got=%h want=%h", idx, bus.seg, exp_seg(idx, 12, 1'b0));
      end
      // value changes underneath the error display are still converted
      for (int r = 0; r < 4; r++) begin
         v = int'($urandom_range(63));
         @(negedge clk);
         bus.err_flag = 1'b1;
         bus.result   = 6'(v);
         repeat (20) @(negedge clk);
         get_digit(3, s, ok);
         total++;
         if (!ok || s !== 7'h06) begin
            bad++;
            $display("FAIL err_bg_d3 ok=%0b got=%h want=06", ok, s);
         end
         bus.err_flag = 1'b0;
         for (int d = 0; d < 4; d++) begin
            get_digit(d, s, ok);
            total++;
            if (!ok || s !== exp_seg(d, v, 1'b0)) begin
               bad++;
               $display("FAIL err_bg_%0d_d%0d ok=%0b got=%h want=%h", v, d, ok, s,
                        exp_seg(d, v, 1'b0));
            end
         end
      end
   endtask

   task automatic test_reset_midconv;
      int busy_cnt;
      logic [6:0] s;
      bit ok;
      settle(44);
      @(negedge clk);
      bus.result = 6'd45;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      total++;
      if ({bus.seg, bus.an, bus.dp, bus.busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL async_reset seg=%h an=%h dp=%b busy=%b want 7f f 1 0",
                  bus.seg, bus.an, bus.dp, bus.busy);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      busy_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
      end
      total++;
      if (busy_cnt != 7) begin
         bad++;
         $display("FAIL rerun_busy_len got=%0d want=7", busy_cnt);
      end
      for (int d = 0; d < 4; d++) begin
         get_digit(d, s, ok);
         total++;
         if (!ok || s !== exp_seg(d, 45, 1'b0)) begin
            bad++;
            $display("FAIL rerun_d%0d ok=%0b got=%h want=%h", d, ok, s, exp_seg(d, 45, 1'b0));
         end
      end
   endtask

   initial begin
      bus.result   = 6'd0;
      bus.err_flag = 1'b0;
      test_reset();
      test_values();
      test_midchange();
      test_error();
      test_reset_midconv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
